// File: rtl/morse_decoder.sv
// Receive side of the morse link: phase-locks a mid-unit sample strobe to the
// first mark edge, classifies marks/gaps and decodes the S..Z letter code.
module morse_decoder #(
    parameter int CLKS_PER_UNIT = 25000000,
    parameter int CNT_W         = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       morse_code,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       decode_error,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_UNIT / 2 - 1);
    localparam logic [CNT_W-1:0] UNIT_LOAD = CNT_W'(CLKS_PER_UNIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_nx;
    logic [1:0]       sync_q;
    logic             m;
    logic [CNT_W-1:0] unit_cnt;
    logic             start;
    logic             tick;

    logic [2:0] mark_len, mark_len_nx;
    logic [1:0] zero_len, zero_len_nx;
    logic [2:0] sym_cnt, sym_cnt_nx;
    logic [3:0] sym, sym_nx;
    logic       err, err_nx;
    logic [2:0] letter_nx;
    logic       valid_nx, error_nx;
    logic [3:0] lk;

    // Returns {hit, code}; sym holds symbols MSB-first, unused low bits are 0.
    function automatic logic [3:0] lookup(input logic [2:0] cnt, input logic [3:0] s);
        logic [3:0] r;
        r = 4'b0000;
        case ({cnt, s})
            {3'd3, 4'b0000}: r = {1'b1, 3'd0};  // S ...
            {3'd1, 4'b1000}: r = {1'b1, 3'd1};  // T -
            {3'd3, 4'b0010}: r = {1'b1, 3'd2};  // U ..-
            {3'd4, 4'b0001}: r = {1'b1, 3'd3};  // V ...-
            {3'd3, 4'b0110}: r = {1'b1, 3'd4};  // W .--
            {3'd4, 4'b1001}: r = {1'b1, 3'd5};  // X -..-
            {3'd4, 4'b1011}: r = {1'b1, 3'd6};  // Y -.--
            {3'd4, 4'b1100}: r = {1'b1, 3'd7};  // Z --..
            default:         r = 4'b0000;
        endcase
        return r;
    endfunction

    assign m     = sync_q[1];
    assign start = (state == IDLE) && m;
    assign tick  = !start && (unit_cnt == '0);
    assign busy  = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q   <= 2'b00;
            unit_cnt <= '0;
        end else begin
            sync_q <= {sync_q[0], morse_code};
            // Half-unit load on the first edge puts every later tick mid-unit.
            if (start)
                unit_cnt <= HALF_LOAD;
            else if (unit_cnt == '0)
                unit_cnt <= UNIT_LOAD;
            else
                unit_cnt <= unit_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            mark_len     <= 3'd0;
            zero_len     <= 2'd0;
            sym_cnt      <= 3'd0;
            sym          <= 4'd0;
            err          <= 1'b0;
            letter       <= 3'd0;
            letter_valid <= 1'b0;
            decode_error <= 1'b0;
        end else begin
            state        <= state_nx;
            mark_len     <= mark_len_nx;
            zero_len     <= zero_len_nx;
            sym_cnt      <= sym_cnt_nx;
            sym          <= sym_nx;
            err          <= err_nx;
            letter       <= letter_nx;
            letter_valid <= valid_nx;
            decode_error <= error_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        mark_len_nx = mark_len;
        zero_len_nx = zero_len;
        sym_cnt_nx  = sym_cnt;
        sym_nx      = sym;
        err_nx      = err;
        letter_nx   = letter;
        valid_nx    = 1'b0;
        error_nx    = 1'b0;
        lk          = lookup(sym_cnt, sym);

        case (state)
            IDLE: begin
                if (m) begin
                    mark_len_nx = 3'd0;
                    zero_len_nx = 2'd0;
                    sym_cnt_nx  = 3'd0;
                    sym_nx      = 4'd0;
                    err_nx      = 1'b0;
                    state_nx    = MARK;
                end
            end
            MARK: begin
                if (tick) begin
                    if (m) begin
                        if (mark_len != 3'd7)
                            mark_len_nx = mark_len + 3'd1;
                    end else begin
                        if (mark_len != 3'd1 && mark_len != 3'd3)
                            err_nx = 1'b1;
                        if (sym_cnt == 3'd4) begin
                            err_nx = 1'b1;
                        end else begin
                            sym_nx[2'd3 - sym_cnt[1:0]] = (mark_len == 3'd3);
                            sym_cnt_nx = sym_cnt + 3'd1;
                        end
                        zero_len_nx = 2'd1;
                        state_nx    = SPACE;
                    end
                end
            end
            SPACE: begin
                if (tick) begin
                    if (!m) begin
                        zero_len_nx = zero_len + 2'd1;
                        // Third zero unit closes the letter.
                        if (zero_len == 2'd2) begin
                            if (!err && lk[3]) begin
                                letter_nx = lk[2:0];
                                valid_nx  = 1'b1;
                            end else begin
                                error_nx = 1'b1;
                            end
                            state_nx = IDLE;
                        end
                    end else begin
                        // A two-unit gap is neither element nor letter spacing.
                        if (zero_len == 2'd2)
                            err_nx = 1'b1;
                        mark_len_nx = 3'd1;
                        state_nx    = MARK;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
